// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and encodings for the MEM-stage bus arbiter.
// Optional build macro used by the top: MEM_ARB_STALL_CNT_EN.
package mem_arb_pkg;

  // Addresses at or above this go to the peripheral, everything below to RAM.
  localparam logic [31:0] DEF_PERIPH_BASE = 32'h4000_0000;

  // Consecutive refusals a waiting DMA request tolerates before it is forced through.
  localparam int DEF_WAIT_LIMIT = 4;

  // Which requester owns the shared bus in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_DMA  = 2'd2
  } sel_e;

  // Which target an address maps to.
  typedef enum logic {
    TGT_RAM = 1'b0,
    TGT_PER = 1'b1
  } tgt_e;

  // Unsigned address-space split between RAM and peripheral.
  function automatic tgt_e addr_target(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) ? TGT_PER : TGT_RAM;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the CPU port, DMA port and memory-side bus of the MEM-stage arbiter.
// master: the arbiter's view (drives strobes, shared bus, read data, stall, ack).
// slave : the surrounding pipeline, DMA engine and memories.
interface mem_bus_arbiter_if;

  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;

  logic        ram_rd;
  logic        ram_wr;
  logic        per_rd;
  logic        per_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] per_rdata;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output ram_rd, ram_wr, per_rd, per_wr, bus_addr, bus_wdata,
    input  ram_rdata, per_rdata
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  ram_rd, ram_wr, per_rd, per_wr, bus_addr, bus_wdata,
    output ram_rdata, per_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_decode.sv
// Address decoder for the granted bus address: one-hot RAM / peripheral select.
module mem_arb_decode
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE
) (
  input  logic [31:0] addr,
  output logic        ram_sel,
  output logic        per_sel
);

  tgt_e tgt;

  // Classify the address and expand to one-hot selects.
  always_comb begin
    tgt     = addr_target(addr, PERIPH_BASE);
    ram_sel = (tgt == TGT_RAM);
    per_sel = (tgt == TGT_PER);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// MEM-stage bus arbiter: shares DataMem/Peripheral between the CPU MEM stage
// and a DMA requester. CPU has priority; a DMA request refused WAIT_LIMIT
// cycles in a row is forced through, stalling the CPU for that cycle.
// Optional build macro MEM_ARB_STALL_CNT_EN adds a saturating stall-cycle
// counter (stall_cnt) with a synchronous clear input (stall_cnt_clr).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter int          WAIT_LIMIT  = DEF_WAIT_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
`ifdef MEM_ARB_STALL_CNT_EN
  ,
  input  logic               stall_cnt_clr,
  output logic [15:0]        stall_cnt
`endif
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_LIMIT);

  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;
  logic        cpu_req;
  logic        force_dma;
  logic        gnt_cpu;
  logic        gnt_dma;
  sel_e        sel;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        gnt_rd;
  logic        gnt_wr;
  logic        ram_sel;
  logic        per_sel;
  logic [31:0] tgt_rdata;

  // Per-cycle grant; reset suppresses both grants so an in-flight access is dropped.
  always_comb begin
    cpu_req   = bus.cpu_rd | bus.cpu_wr;
    force_dma = (wait_cnt == WAIT_LIM);
    gnt_cpu   = ~reset & cpu_req & ~force_dma;
    gnt_dma   = ~reset & bus.dma_req & (~cpu_req | force_dma);
    sel       = SEL_NONE;
    if (gnt_dma) begin
      sel = SEL_DMA;
    end else if (gnt_cpu) begin
      sel = SEL_CPU;
    end
  end

  // Refusal counter: clears on grant or idle, counts refusals, capped at the limit.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!bus.dma_req || gnt_dma) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt < WAIT_LIM) begin
      wait_cnt_nxt = wait_cnt + 4'd1;
    end
  end

  // Refusal counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Route the granted port onto the shared bus; write wins when both CPU strobes are set.
  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    case (sel)
      SEL_CPU: begin
        gnt_addr  = bus.cpu_addr;
        gnt_wdata = bus.cpu_wdata;
        gnt_wr    = bus.cpu_wr;
        gnt_rd    = bus.cpu_rd & ~bus.cpu_wr;
      end
      SEL_DMA: begin
        gnt_addr  = bus.dma_addr;
        gnt_wdata = bus.dma_wdata;
        gnt_wr    = bus.dma_wr;
        gnt_rd    = ~bus.dma_wr;
      end
      default: ;
    endcase
  end

  mem_arb_decode #(
    .PERIPH_BASE (PERIPH_BASE)
  ) u_decode (
    .addr    (gnt_addr),
    .ram_sel (ram_sel),
    .per_sel (per_sel)
  );

  // Target strobes, shared bus, zero-latency read return, handshake outputs.
  always_comb begin
    bus.ram_rd    = gnt_rd & ram_sel;
    bus.ram_wr    = gnt_wr & ram_sel;
    bus.per_rd    = gnt_rd & per_sel;
    bus.per_wr    = gnt_wr & per_sel;
    bus.bus_addr  = gnt_addr;
    bus.bus_wdata = gnt_wdata;
    tgt_rdata     = per_sel ? bus.per_rdata : bus.ram_rdata;
    bus.cpu_rdata = (sel == SEL_CPU && gnt_rd) ? tgt_rdata : '0;
    bus.dma_rdata = (sel == SEL_DMA && gnt_rd) ? tgt_rdata : '0;
    bus.dma_ack   = gnt_dma;
    bus.cpu_stall = ~reset & cpu_req & ~gnt_cpu;
  end

`ifdef MEM_ARB_STALL_CNT_EN
  // Saturating count of stalled cycles; clear takes precedence over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (bus.cpu_stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level ownership model.
module tb_mem_bus_arbiter;

  localparam int          WL = 4;
  localparam logic [31:0] PB = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

`ifdef MEM_ARB_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [15:0] stall_cnt;
`endif

  mem_bus_arbiter #(
    .PERIPH_BASE (PB),
    .WAIT_LIMIT  (WL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference state: consecutive DMA refusals, owner this cycle, stall, stall counter.
  int          refusals = 0;
  int          m_owner  = 0;   // 0 none, 1 cpu, 2 dma
  bit          m_stall  = 0;
  logic [15:0] m_scnt   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decide who owns the bus from the arbitration rules and check every output.
  task automatic settle_check();
    bit          cpu_req, forced, rd, wr, per;
    logic [31:0] a, wd, tdata;
    int          owner;
    #1;
    cpu_req = bus.cpu_rd | bus.cpu_wr;
    forced  = (refusals == WL);
    owner   = 0;
    if (!reset) begin
      if (forced)              owner = bus.dma_req ? 2 : 0;
      else if (cpu_req)        owner = 1;
      else if (bus.dma_req)    owner = 2;
    end
    m_owner = owner;
    m_stall = !reset && cpu_req && owner != 1;
    a = '0; wd = '0; rd = 0; wr = 0;
    if (owner == 1) begin
      a = bus.cpu_addr; wd = bus.cpu_wdata; wr = bus.cpu_wr; rd = !bus.cpu_wr;
    end else if (owner == 2) begin
      a = bus.dma_addr; wd = bus.dma_wdata; wr = bus.dma_wr; rd = !bus.dma_wr;
    end
    per   = (a >= PB);
    tdata = per ? bus.per_rdata : bus.ram_rdata;
    chk("ram_rd",    bus.ram_rd,    32'(rd && !per));
    chk("ram_wr",    bus.ram_wr,    32'(wr && !per));
    chk("per_rd",    bus.per_rd,    32'(rd && per));
    chk("per_wr",    bus.per_wr,    32'(wr && per));
    chk("bus_addr",  bus.bus_addr,  a);
    chk("bus_wdata", bus.bus_wdata, wd);
    chk("cpu_rdata", bus.cpu_rdata, (owner == 1 && rd) ? tdata : 32'h0);
    chk("dma_rdata", bus.dma_rdata, (owner == 2 && rd) ? tdata : 32'h0);
    chk("dma_ack",   bus.dma_ack,   32'(owner == 2));
    chk("cpu_stall", bus.cpu_stall, 32'(m_stall));
`ifdef MEM_ARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(m_scnt));
`endif
  endtask

  // Advance one clock and update the reference state.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      refusals = 0;
      m_scnt   = '0;
    end else begin
      if (bus.dma_req && m_owner != 2) refusals++;
      else refusals = 0;
`ifdef MEM_ARB_STALL_CNT_EN
      if (stall_cnt_clr) m_scnt = '0;
      else if (m_stall && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
`endif
    end
    #1;
  endtask

  task automatic drive_cpu(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dma(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dma_req = req; bus.dma_wr = wr; bus.dma_addr = addr; bus.dma_wdata = wdata;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h3FFF_FFFC;
      1:       r = 32'h4000_0000;
      2:       r = $urandom & 32'h0000_FFFC;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    bit cpu_hold;
    bit dma_pend;
    int c;

    // Reset with busy-looking inputs: everything must read as zero.
    reset = 1'b1;
    drive_cpu(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    drive_dma(1'b1, 1'b0, 32'h4000_0004, 32'h1234_5678);
    bus.ram_rdata = 32'h1111_2222;
    bus.per_rdata = 32'h3333_4444;
`ifdef MEM_ARB_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    @(posedge clk);
    #1;
    settle_check();
    tick();
    settle_check();
    tick();

    reset = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dma(1'b0, 1'b0, '0, '0);

    // CPU read from RAM alone.
    drive_cpu(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    bus.ram_rdata = 32'hCAFE_0010;
    settle_check();
    chk("t_cpu_rd_ram_rd", bus.ram_rd, 32'h1);
    chk("t_cpu_rd_data", bus.cpu_rdata, 32'hCAFE_0010);
    tick();

    // CPU write to peripheral alone.
    drive_cpu(1'b0, 1'b1, 32'h4000_000C, 32'hA5A5_1234);
    settle_check();
    chk("t_cpu_wr_per_wr", bus.per_wr, 32'h1);
    chk("t_cpu_wr_wdata", bus.bus_wdata, 32'hA5A5_1234);
    tick();

    // DMA read from RAM with the CPU idle: one-cycle ack.
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dma(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    bus.ram_rdata = 32'hBEEF_0020;
    settle_check();
    chk("t_dma_ack", bus.dma_ack, 32'h1);
    chk("t_dma_rdata", bus.dma_rdata, 32'hBEEF_0020);
    tick();
    drive_dma(1'b0, 1'b0, '0, '0);
    settle_check();
    chk("t_dma_ack_drop", bus.dma_ack, 32'h0);
    tick();

    // Continuous CPU traffic against a held DMA request: forced every fifth cycle.
    drive_cpu(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    drive_dma(1'b1, 1'b1, 32'h4000_0040, 32'h0BAD_F00D);
    for (int i = 0; i < 15; i++) begin
      bus.ram_rdata = $urandom;
      bus.per_rdata = $urandom;
      settle_check();
      chk("pat_ack",   bus.dma_ack,   32'(i % 5 == 4));
      chk("pat_stall", bus.cpu_stall, 32'(i % 5 == 4));
      tick();
    end
`ifdef MEM_ARB_STALL_CNT_EN
    chk("scnt_three", stall_cnt, 32'd3);
`endif
    for (int i = 0; i < 5; i++) begin
`ifdef MEM_ARB_STALL_CNT_EN
      stall_cnt_clr = (i == 4);
`endif
      settle_check();
      chk("pat2_ack", bus.dma_ack, 32'(i == 4));
      tick();
    end
`ifdef MEM_ARB_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
    chk("scnt_clr_wins", stall_cnt, 32'd0);
`endif

    // Build up two refusals, then reset in the middle of a CPU write.
    for (int i = 0; i < 2; i++) begin
      settle_check();
      tick();
    end
    drive_cpu(1'b0, 1'b1, 32'h0000_0040, 32'h7777_8888);
    settle_check();
    chk("mid_ram_wr_before", bus.ram_wr, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_ram_wr_async", bus.ram_wr, 32'h0);
    chk("mid_per_wr_async", bus.per_wr, 32'h0);
    chk("mid_stall_async",  bus.cpu_stall, 32'h0);
    tick();
    settle_check();
    tick();
    reset = 1'b0;

    // After release the refusal count starts from zero again.
    for (int i = 0; i < 5; i++) begin
      settle_check();
      if (i == 0) chk("post_rst_ram_wr", bus.ram_wr, 32'h1);
      chk("post_rst_ack", bus.dma_ack, 32'(i == 4));
      tick();
    end

    // Randomized traffic obeying the hold-while-stalled / hold-until-ack rules.
    cpu_hold = 0;
    dma_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cpu_hold) begin
        c = $urandom_range(0, 9);
        drive_cpu(c inside {1, 2, 3, 4, 9}, c inside {5, 6, 7, 8, 9}, pick_addr(), $urandom);
      end
      if (!dma_pend) drive_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom);
      bus.ram_rdata = $urandom;
      bus.per_rdata = $urandom;
`ifdef MEM_ARB_STALL_CNT_EN
      stall_cnt_clr = ($urandom_range(0, 15) == 0);
`endif
      settle_check();
      cpu_hold = m_stall;
      dma_pend = bus.dma_req && m_owner != 2;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
